des_key_sched_enc: RTL and testbench
====================================

# des_key_sched_enc

Iterative DES encryption key scheduler. It accepts a 64-bit DES key on a load strobe and emits the sixteen 48-bit round subkeys in encryption order, K1 first through K16 last. It emits at most one subkey per cycle over a valid/ready stream. It complements the pipelined decryption key schedule: it feeds a round-serial DES/TDES datapath that consumes one subkey per round and may stall.

## Interface
- PARITY_CHECK, default 0: when 1, check odd parity of each key byte at load and report it on parity_err; when 0, parity_err is tied to 0.
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- key_in  in  64  DES key; FIPS 46-3 bit 1 = key_in[63], bit 64 = key_in[0]; parity bits are key_in[8k], k=0..7.
- key_load  in  1  load strobe; sampled only in IDLE.
- busy  out  1  high while a schedule is in progress (state RUN).
- sk_valid  out  1  subkey available on sk_data.
- sk_ready  in  1  consumer accepts the subkey; a transfer occurs when sk_valid & sk_ready.
- sk_data  out  48  current subkey, PC-2 output; FIPS bit 1 = sk_data[47].
- sk_round  out  4  index of the current subkey, 0..15 (0 = K1).
- sk_last  out  1  sk_valid & (sk_round == 15).
- parity_err  out  1  registered parity result of the last loaded key.

## Operation
- State: two 28-bit halves C and D, a 4-bit round counter, and a 1-bit FSM (IDLE, RUN).
- IDLE, key_load=1: {C,D} <= PC-1(key_in), then left-rotate each half by 1 (the K1 shift). round <= 0. parity_err <= (PARITY_CHECK && any byte of key_in has even parity). Go to RUN.
- RUN: sk_valid=1; sk_data = PC-2({C,D}), driven combinationally from registers, so it stays stable under stall.
- RUN with a transfer and round < 15: round <= round+1; rotate C and D left by S[round+1], where S = 1 for indices 0, 1, 8, 15 and 2 otherwise.
- RUN with a transfer and round == 15: go to IDLE. sk_valid drops the next cycle. After 16 rotations (28 total) C and D equal the PC-1 halves again; no other cleanup is needed.
- RUN without a transfer: all state holds.
- key_load in RUN is ignored, including in the cycle of the final transfer. No queueing; a new key is accepted only from IDLE.
- key_in is sampled only at the load edge; it may change afterwards.
- parity_err does not block the schedule. Subkeys are generated regardless; it holds until the next accepted load.
- Reset, asynchronous, at any time including mid-schedule: state IDLE; C, D, round = 0; parity_err = 0. Therefore busy=0, sk_valid=0, sk_round=0, sk_last=0, and sk_data = PC-2(0) = 48'h0. An interrupted schedule is discarded and is not resumed.

## Timing
- Load latency: key_load sampled high at edge N (in IDLE) gives sk_valid=1 with K1 from after edge N. Latency is 1 cycle.
- Throughput: with sk_ready held high, K1..K16 appear on 16 consecutive cycles. sk_valid falls after the edge that transfers K16.
- Minimum load-to-load spacing is 17 cycles: 16 transfers, then 1 IDLE cycle in which key_load is accepted.
- busy == sk_valid at all times.
- sk_data, sk_round and sk_last change only on a transfer edge or a load edge.
- Rotation and PC-2 are one level of combinational logic on registered state. There is no multi-cycle path.

## Test plan
- FIPS vector: key_in=64'h133457799BBCDFF1, pulse key_load, sk_ready=1 → the next cycle shows sk_round=0 and sk_data=48'h1B02EFFC7072. The following cycle shows sk_data=48'h79AED9DBC9E5. The 16th subkey is 48'hCB3D8B0E17F5 with sk_last=1, then sk_valid=0. With PARITY_CHECK=1, parity_err=0.
- Backpressure: same key, sk_ready toggled pseudo-randomly → exactly 16 transfers, identical subkey sequence. sk_data and sk_round hold while sk_ready=0.
- Parity and zero key: PARITY_CHECK=1, key_in=64'h0 → parity_err=1 after load; all 16 subkeys are 48'h0. The next load of 64'h133457799BBCDFF1 clears parity_err to 0.
- Load while busy: pulse key_load with a different key at rounds 3 and 15 (the final-transfer cycle) → ignored; the sequence matches the first key. A load in the following IDLE cycle starts the new schedule.
- Reset mid-schedule: assert nrst low at round 7 while sk_valid=1 → outputs are at reset values immediately (asynchronously). After release, a fresh load produces K1 correctly.
- Back-to-back: two keys loaded at minimum spacing → 32 subkeys matching a software DES key-schedule model; sk_valid is low for exactly 1 cycle between the two sequences.

Source files
------------

// File: rtl/des_key_sched_enc.sv
// des_key_sched_enc: iterative DES encryption key schedule, emitting K1..K16 over a valid/ready stream
module des_key_sched_enc #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    output logic        busy,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk_data,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        parity_err
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };
    state_t      state, state_nxt;
    logic [27:0] c, d, c_nxt, d_nxt;
    logic [3:0]  round, round_nxt, round_inc;
    logic        parity_nxt;
    logic [55:0] pc1_out, cd;
    logic [7:0]  byte_even;
    logic        xfer, two_step;
    function automatic logic [27:0] rol(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction
    assign cd = {c, d};
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_out[55-i] = key_in[64-PC1[i]];
    end
    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign sk_data[47-i] = cd[56-PC2[i]];
    end
    for (genvar i = 0; i < 8; i++) begin : g_par
        assign byte_even[i] = ~^key_in[8*i +: 8];
    end
    assign round_inc  = round + 4'd1;
    assign two_step   = !(round_inc == 4'd0 || round_inc == 4'd1 || round_inc == 4'd8 || round_inc == 4'd15);
    assign busy       = state == RUN;
    assign sk_valid   = busy;
    assign xfer       = busy && sk_ready;
    assign sk_round   = round;
    assign sk_last    = sk_valid && round == 4'd15;
    // next state: load from IDLE applies PC-1 plus the K1 shift; each non-final transfer advances one round
    always_comb begin
        state_nxt  = state;
        c_nxt      = c;
        d_nxt      = d;
        round_nxt  = round;
        parity_nxt = parity_err;
        if (state == IDLE && key_load) begin
            state_nxt  = RUN;
            c_nxt      = rol(pc1_out[55:28], 1'b0);
            d_nxt      = rol(pc1_out[27:0], 1'b0);
            round_nxt  = 4'd0;
            parity_nxt = PARITY_CHECK && (|byte_even);
        end else if (xfer && round == 4'd15) begin
            state_nxt  = IDLE;
        end else if (xfer) begin
            round_nxt  = round_inc;
            c_nxt      = rol(c, two_step);
            d_nxt      = rol(d, two_step);
        end
    end
    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            c          <= '0;
            d          <= '0;
            round      <= '0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            c          <= c_nxt;
            d          <= d_nxt;
            round      <= round_nxt;
            parity_err <= parity_nxt;
        end
    end
endmodule

// File: tb/tb_des_key_sched_enc.sv
// tb_des_key_sched_enc: directed vector bench for the DES encryption key schedule
module tb_des_key_sched_enc;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_load = 1'b0;
    logic        sk_ready = 1'b0;
    logic        busy, sk_valid, sk_last, parity_err;
    logic [47:0] sk_data;
    logic [3:0]  sk_round;
    int          total = 0;
    int          bad = 0;
    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY1_BADPAR = 64'h133457799BBCDFF0;
    localparam logic [63:0] OTHER = 64'hFEDCBA9876543210;
    typedef struct {
        logic [63:0]       key;
        logic [15:0][47:0] ks;
        logic              perr;
    } vec_t;
    vec_t        vecs [3];
    logic [47:0] fips_ks [16];
    logic [15:0][47:0] k1_ks, k1n_ks;

    des_key_sched_enc #(.PARITY_CHECK(1'b1)) dut (
        .clk(clk), .nrst(nrst), .key_in(key_in), .key_load(key_load),
        .busy(busy), .sk_valid(sk_valid), .sk_ready(sk_ready), .sk_data(sk_data),
        .sk_round(sk_round), .sk_last(sk_last), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_valid"}, 64'(sk_valid), 64'd0);
        chk({name, "_round"}, 64'(sk_round), 64'd0);
        chk({name, "_last"}, 64'(sk_last), 64'd0);
        chk({name, "_data"}, 64'(sk_data), 64'd0);
        chk({name, "_perr"}, 64'(parity_err), 64'd0);
    endtask

    // called at a negedge in IDLE; returns at the negedge showing K1
    task automatic load(input logic [63:0] k);
        key_in = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready high with ignored loads at rounds 3 and 15
    task automatic run_seq(input string name, input logic [15:0][47:0] ks, input logic perr, input int mode);
        int idx = 0;
        int cyc = 0;
        chk({name, "_perr"}, 64'(parity_err), 64'(perr));
        while (idx < 16 && cyc < 200) begin
            chk({name, "_valid"}, 64'(sk_valid), 64'd1);
            chk({name, "_busy"}, 64'(busy), 64'd1);
            chk({name, "_data"}, 64'(sk_data), 64'(ks[idx]));
            chk({name, "_round"}, 64'(sk_round), 64'(idx));
            chk({name, "_last"}, 64'(sk_last), 64'(idx == 15));
            sk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            key_load = (mode == 2) && (idx == 3 || idx == 15);
            if (key_load) key_in = OTHER;
            if (sk_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        key_load = 1'b0;
        sk_ready = 1'b0;
        chk({name, "_count"}, 64'(idx), 64'd16);
        chk({name, "_end_valid"}, 64'(sk_valid), 64'd0);
        chk({name, "_end_busy"}, 64'(busy), 64'd0);
        chk({name, "_end_last"}, 64'(sk_last), 64'd0);
        chk({name, "_end_perr"}, 64'(parity_err), 64'(perr));
    endtask

    initial begin
        fips_ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        for (int i = 0; i < 16; i++) begin
            k1_ks[i]  = fips_ks[i];
            k1n_ks[i] = ~fips_ks[i];
        end
        vecs[0].key = 64'h0; vecs[0].ks = '0;     vecs[0].perr = 1'b1;
        vecs[1].key = KEY1;  vecs[1].ks = k1_ks;  vecs[1].perr = 1'b0;
        vecs[2].key = ~KEY1; vecs[2].ks = k1n_ks; vecs[2].perr = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        // zero key, FIPS key, complemented key; loads at minimum spacing
        for (int v = 0; v < 3; v++) begin
            load(vecs[v].key);
            run_seq($sformatf("vec%0d", v), vecs[v].ks, vecs[v].perr, 0);
        end

        @(negedge clk);
        load(KEY1);
        run_seq("backpressure", k1_ks, 1'b0, 1);

        load(KEY1);
        run_seq("load_busy", k1_ks, 1'b0, 2);
        load(~KEY1);
        run_seq("load_after", k1n_ks, 1'b0, 0);

        load(KEY1_BADPAR);
        for (int i = 0; i < 7; i++) begin
            chk("mid_data", 64'(sk_data), 64'(fips_ks[i]));
            sk_ready = 1'b1;
            @(negedge clk);
        end
        sk_ready = 1'b0;
        chk("mid_round", 64'(sk_round), 64'd7);
        chk("mid_data7", 64'(sk_data), 64'(fips_ks[7]));
        chk("mid_perr", 64'(parity_err), 64'd1);
        #1 nrst = 1'b0;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        chk_reset_outputs("held_reset");
        nrst = 1'b1;
        @(negedge clk);
        load(KEY1);
        run_seq("post_reset", k1_ks, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
